// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one ALU among NUM_REQ requesters.
//
// Holds at most one operation in flight. A grant is made in IDLE, the latched
// operands are offered to the ALU in ISSUE, the result is captured in WAIT, and
// the owning requester is answered in RESP.
//
// Optional build macro: ALU_ARBITER_PERF_EN adds saturating perf_ops/perf_stall
// counters; without it both outputs are tied to zero and no counters exist.
//
// Ports:
//   clk, reset          clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (req_ready one-hot or zero)
//   req_a, req_b        flattened operands, port i at [i*WIDTH +: WIDTH]
//   req_op              per-requester op, 0 add / 1 multiply
//   rsp_valid/rsp_ready per-requester response handshake (rsp_valid one-hot or zero)
//   rsp_data            result shared by all requesters
//   alu_a/b/op/valid    request to the shared ALU, alu_ready its acceptance
//   alu_result(_valid)  result from the ALU, alu_result_ready its acceptance
//   perf_ops/perf_stall completed responses / RESP cycles stalled by the owner
module alu_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_op,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic                     alu_op,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_result_valid,
    output logic                     alu_result_ready,
    output logic [31:0]              perf_ops,
    output logic [31:0]              perf_stall
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW    = IDX_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_mul;
    logic [WIDTH-1:0]   rsp_data_r;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [CW-1:0]      cand;
    logic               rsp_done;

    // Scan upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == StIdle && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == StResp) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    // Response handshake; non-owner rsp_ready bits never matter.
    assign rsp_done         = (state == StResp) && rsp_ready[owner];

    assign alu_valid        = (state == StIssue);
    assign alu_result_ready = (state == StWait);
    assign alu_a            = op_a;
    assign alu_b            = op_b;
    assign alu_op           = op_mul;
    assign rsp_data         = rsp_data_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_mul     <= 1'b0;
            rsp_data_r <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (grant_found) begin
                        owner  <= grant_idx;
                        op_a   <= req_a[grant_idx*WIDTH +: WIDTH];
                        op_b   <= req_b[grant_idx*WIDTH +: WIDTH];
                        op_mul <= req_op[grant_idx];
                        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    if (alu_ready) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (alu_result_valid) begin
                        rsp_data_r <= alu_result;
                        state      <= StResp;
                    end
                end
                StResp: begin
                    // Returning to IDLE guarantees one idle cycle before the next grant.
                    if (rsp_done) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef ALU_ARBITER_PERF_EN
    logic [31:0] perf_ops_r;
    logic [31:0] perf_stall_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops_r   <= '0;
            perf_stall_r <= '0;
        end else begin
            if (rsp_done && perf_ops_r != 32'hFFFF_FFFF) begin
                perf_ops_r <= perf_ops_r + 32'd1;
            end
            if (state == StResp && !rsp_ready[owner] && perf_stall_r != 32'hFFFF_FFFF) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_r;
    assign perf_stall = perf_stall_r;
`else
    assign perf_ops   = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (WIDTH=32, NUM_REQ=4).
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int N = 4;

`ifdef ALU_ARBITER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_op;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_op;
    logic           alu_valid;
    logic           alu_ready;
    logic [W-1:0]   alu_result;
    logic           alu_result_valid;
    logic           alu_result_ready;
    logic [31:0]    perf_ops;
    logic [31:0]    perf_stall;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_op           (req_op),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_ready        (rsp_ready),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_op           (alu_op),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .alu_result_ready (alu_result_ready),
        .perf_ops         (perf_ops),
        .perf_stall       (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic op);
        req_a[p*W +: W] = a;
        req_b[p*W +: W] = b;
        req_op[p]       = op;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, ".rsp_data"}, rsp_data, 32'h0);
        chk({tag, ".alu_valid"}, 32'(alu_valid), 32'h0);
        chk({tag, ".alu_a"}, alu_a, 32'h0);
        chk({tag, ".alu_b"}, alu_b, 32'h0);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'h0);
        chk({tag, ".alu_result_ready"}, 32'(alu_result_ready), 32'h0);
        chk({tag, ".perf_ops"}, perf_ops, 32'h0);
        chk({tag, ".perf_stall"}, perf_stall, 32'h0);
    endtask

    initial begin
        int          exp_port;
        logic [31:0] exp_ops;
        logic [31:0] exp_stall;

        reset            = 1'b1;
        req_valid        = '0;
        req_a            = '0;
        req_b            = '0;
        req_op           = '0;
        rsp_ready        = '0;
        alu_ready        = 1'b0;
        alu_result       = '0;
        alu_result_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Single add on port 1
        tick();
        set_port(1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        req_valid = 4'b0010;
        #1;
        chk("single.grant", 32'(req_ready), 32'h2);
        tick();                                   // ISSUE
        req_valid = '0;
        #1;
        chk("single.issue_valid", 32'(alu_valid), 32'h1);
        chk("single.alu_a", alu_a, 32'h3F80_0000);
        chk("single.alu_b", alu_b, 32'h4000_0000);
        chk("single.alu_op", 32'(alu_op), 32'h0);
        chk("single.no_ready_issue", 32'(req_ready), 32'h0);
        alu_ready = 1'b1;
        tick();                                   // WAIT
        alu_ready = 1'b0;
        chk("single.wait_rready", 32'(alu_result_ready), 32'h1);
        chk("single.wait_no_valid", 32'(alu_valid), 32'h0);
        alu_result       = 32'h4040_0000;
        alu_result_valid = 1'b1;
        tick();                                   // RESP
        alu_result_valid = 1'b0;
        chk("single.rsp_valid", 32'(rsp_valid), 32'h2);
        chk("single.rsp_data", rsp_data, 32'h4040_0000);
        chk("single.resp_rready", 32'(alu_result_ready), 32'h0);
        rsp_ready = 4'b0010;
        tick();                                   // IDLE
        rsp_ready = '0;
        chk("single.idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("single.idle_alu_valid", 32'(alu_valid), 32'h0);
        chk("single.idle_rready", 32'(alu_result_ready), 32'h0);

        // Spurious ALU result while idle
        alu_result       = 32'hBAD0_0000;
        alu_result_valid = 1'b1;
        #1;
        chk("spur.rready", 32'(alu_result_ready), 32'h0);
        tick();
        chk("spur.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("spur.alu_valid", 32'(alu_valid), 32'h0);
        chk("spur.rready2", 32'(alu_result_ready), 32'h0);
        alu_result_valid = 1'b0;

        // Round robin with all ports valid: after reset expect 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < N; p++) begin
            set_port(p, 32'h100 + 32'(p), 32'h200 + 32'(p), p[0]);
        end
        req_valid        = 4'b1111;
        rsp_ready        = 4'b1111;
        alu_ready        = 1'b1;
        alu_result_valid = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            exp_port = n % N;
            chk("rr.grant", 32'(req_ready), 32'h1 << exp_port);
            tick();                               // ISSUE
            chk("rr.alu_a", alu_a, 32'h100 + 32'(exp_port));
            chk("rr.alu_op", 32'(alu_op), 32'(exp_port % 2));
            alu_result = 32'hA000_0000 | 32'(n);
            tick();                               // WAIT
            chk("rr.wait", 32'(alu_result_ready), 32'h1);
            tick();                               // RESP
            chk("rr.rsp_valid", 32'(rsp_valid), 32'h1 << exp_port);
            chk("rr.rsp_data", rsp_data, 32'hA000_0000 | 32'(n));
            chk("rr.no_grant_in_resp", 32'(req_ready), 32'h0);
            tick();                               // IDLE
        end
        req_valid        = '0;
        rsp_ready        = '0;
        alu_ready        = 1'b0;
        alu_result_valid = 1'b0;

        // ALU stall in ISSUE: port 2 multiply, others request meanwhile
        set_port(2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("stall.grant", 32'(req_ready), 32'h4);
        tick();                                   // ISSUE
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("stall.alu_valid", 32'(alu_valid), 32'h1);
            chk("stall.alu_a", alu_a, 32'h1234_5678);
            chk("stall.alu_b", alu_b, 32'h9ABC_DEF0);
            chk("stall.alu_op", 32'(alu_op), 32'h1);
            chk("stall.no_grant", 32'(req_ready), 32'h0);
            tick();
        end
        alu_ready = 1'b1;
        tick();                                   // WAIT
        alu_ready = 1'b0;
        req_valid = '0;
        chk("stall.wait", 32'(alu_result_ready), 32'h1);
        alu_result       = 32'hDEAD_BEEF;
        alu_result_valid = 1'b1;
        tick();                                   // RESP
        alu_result_valid = 1'b0;

        // Owner holds off the response for 3 cycles; non-owner readies ignored
        rsp_ready = 4'b1011;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("hold.rsp_valid", 32'(rsp_valid), 32'h4);
            chk("hold.rsp_data", rsp_data, 32'hDEAD_BEEF);
            tick();
        end
        chk("hold.rsp_valid4", 32'(rsp_valid), 32'h4);
        rsp_ready = 4'b0100;
        tick();                                   // IDLE
        rsp_ready = '0;
        chk("hold.done", 32'(rsp_valid), 32'h0);
        exp_ops   = PERF ? 32'd6 : 32'd0;
        exp_stall = PERF ? 32'd3 : 32'd0;
        chk("perf.ops", perf_ops, exp_ops);
        chk("perf.stall", perf_stall, exp_stall);

        // Reset during WAIT discards the operation (port 3 is next in rotation)
        set_port(3, 32'h0000_0005, 32'h0000_0007, 1'b0);
        req_valid = 4'b1000;
        alu_ready = 1'b1;
        #1;
        chk("rst.grant", 32'(req_ready), 32'h8);
        tick();                                   // ISSUE
        req_valid = '0;
        tick();                                   // WAIT
        alu_ready = 1'b0;
        chk("rst.in_wait", 32'(alu_result_ready), 32'h1);
        reset = 1'b1;
        tick();
        chk_reset_outputs("rst");
        reset            = 1'b0;
        alu_result       = 32'h0000_000C;
        alu_result_valid = 1'b1;
        tick();
        chk("rst.late_no_rsp", 32'(rsp_valid), 32'h0);
        chk("rst.late_rready", 32'(alu_result_ready), 32'h0);
        tick();
        chk("rst.late_no_rsp2", 32'(rsp_valid), 32'h0);
        alu_result_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
